// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch-stage next-PC generator.
// Owns the architectural fetch PC, carries each instruction's prediction
// through D and X, and raises flush/redirect when the EXEC outcome disagrees
// with the path that was fetched.
// Optional build macro: FETCH_PC_STATS_EN adds saturating branch and
// mispredict counters (stat_branches, stat_mispredicts).
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [31:0] f_predict_addr,
    input  logic        f_predict_valid,
    input  logic        x_branch_valid,
    input  logic        x_branch_taken,
    input  logic [31:0] x_branch_target,
`ifdef FETCH_PC_STATS_EN
    output logic [15:0] stat_branches,
    output logic [15:0] stat_mispredicts,
`endif
    output logic [31:0] f_pc,
    output logic        f_pc_valid,
    output logic [31:0] d_pc,
    output logic        d_valid,
    output logic [31:0] x_pc,
    output logic        x_valid,
    output logic        flush,
    output logic        x_mispredict
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_REDIR = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] f_pc_q;
    logic [31:0] f_pc_d;
    logic        f_pc_valid_q;

    // F->D tracking registers
    logic [31:0] d_pc_q;
    logic        d_valid_q;
    logic        d_pred_taken_q;
    logic [31:0] d_pred_target_q;

    // D->X tracking registers
    logic [31:0] x_pc_q;
    logic        x_valid_q;
    logic        x_pred_taken_q;
    logic [31:0] x_pred_target_q;

    logic [31:0] x_seq_next_s;
    logic [31:0] x_pred_next_s;
    logic [31:0] x_actual_next_s;
    logic        mispredict_s;

    // Compare the path fetched after the X instruction against its real outcome
    always_comb begin
        x_seq_next_s    = x_pc_q + 32'd4;
        x_pred_next_s   = x_pred_taken_q ? x_pred_target_q : x_seq_next_s;
        x_actual_next_s = x_branch_taken ? x_branch_target : x_seq_next_s;
        mispredict_s    = x_valid_q && x_branch_valid
                          && (x_actual_next_s != x_pred_next_s);
    end

    // Next fetch PC: redirect beats stall, stall beats prediction, else sequential
    always_comb begin
        f_pc_d = f_pc_q;
        if (state_q == ST_BOOT) begin
            f_pc_d = f_pc_q;
        end else if (mispredict_s) begin
            f_pc_d = x_actual_next_s;
        end else if (stall) begin
            f_pc_d = f_pc_q;
        end else if (f_predict_valid) begin
            f_pc_d = f_predict_addr;
        end else begin
            f_pc_d = f_pc_q + 32'd4;
        end
    end

    // Fetch FSM: boot bubble, normal run, one-cycle redirect bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            f_pc_q       <= RESET_PC;
            f_pc_valid_q <= 1'b0;
        end else begin
            f_pc_q <= f_pc_d;
            case (state_q)
                ST_BOOT: begin
                    state_q      <= ST_RUN;
                    f_pc_valid_q <= 1'b1;
                end
                ST_RUN, ST_REDIR: begin
                    state_q      <= mispredict_s ? ST_REDIR : ST_RUN;
                    f_pc_valid_q <= 1'b1;
                end
                default: begin
                    state_q      <= ST_BOOT;
                    f_pc_q       <= RESET_PC;
                    f_pc_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // D and X tracking: flush kills both, stall holds D and bubbles X
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_pc_q          <= 32'd0;
            d_valid_q       <= 1'b0;
            d_pred_taken_q  <= 1'b0;
            d_pred_target_q <= 32'd0;
            x_pc_q          <= 32'd0;
            x_valid_q       <= 1'b0;
            x_pred_taken_q  <= 1'b0;
            x_pred_target_q <= 32'd0;
        end else if (mispredict_s) begin
            d_valid_q <= 1'b0;
            x_valid_q <= 1'b0;
        end else if (stall) begin
            x_valid_q <= 1'b0;
        end else begin
            d_pc_q          <= f_pc_q;
            d_valid_q       <= f_pc_valid_q;
            d_pred_taken_q  <= f_predict_valid;
            d_pred_target_q <= f_predict_addr;
            x_pc_q          <= d_pc_q;
            x_valid_q       <= d_valid_q;
            x_pred_taken_q  <= d_pred_taken_q;
            x_pred_target_q <= d_pred_target_q;
        end
    end

`ifdef FETCH_PC_STATS_EN
    logic [15:0] stat_branches_q;
    logic [15:0] stat_mispredicts_q;
    logic        branch_resolved_s;

    // A resolved branch is any live X instruction flagged by EXEC
    always_comb begin
        branch_resolved_s = x_valid_q && x_branch_valid;
    end

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q    <= 16'd0;
            stat_mispredicts_q <= 16'd0;
        end else begin
            if (branch_resolved_s && (stat_branches_q != 16'hFFFF)) begin
                stat_branches_q <= stat_branches_q + 16'd1;
            end
            if (mispredict_s && (stat_mispredicts_q != 16'hFFFF)) begin
                stat_mispredicts_q <= stat_mispredicts_q + 16'd1;
            end
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

    assign f_pc         = f_pc_q;
    assign f_pc_valid   = f_pc_valid_q;
    assign d_pc         = d_pc_q;
    assign d_valid      = d_valid_q;
    assign x_pc         = x_pc_q;
    assign x_valid      = x_valid_q;
    assign flush        = mispredict_s;
    assign x_mispredict = mispredict_s;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Testbench for fetch_pc_gen: directed vector table plus randomized run
// against a pipeline-level reference model.
module tb_fetch_pc_gen;

    localparam logic [31:0] RPC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [31:0] f_predict_addr;
    logic        f_predict_valid;
    logic        x_branch_valid;
    logic        x_branch_taken;
    logic [31:0] x_branch_target;
    logic [31:0] f_pc, d_pc, x_pc;
    logic        f_pc_valid, d_valid, x_valid, flush, x_mispredict;

    // wrap-around instance, inputs idle
    logic        w_zero   = 1'b0;
    logic [31:0] w_zero32 = 32'd0;
    logic [31:0] w_f_pc, w_d_pc, w_x_pc;
    logic        w_f_pc_valid, w_d_valid, w_x_valid, w_flush, w_x_mispredict;

`ifdef FETCH_PC_STATS_EN
    logic [15:0] stat_branches, stat_mispredicts, w_sb, w_sm;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_pc_gen #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .f_predict_addr(f_predict_addr), .f_predict_valid(f_predict_valid),
        .x_branch_valid(x_branch_valid), .x_branch_taken(x_branch_taken),
        .x_branch_target(x_branch_target),
`ifdef FETCH_PC_STATS_EN
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts),
`endif
        .f_pc(f_pc), .f_pc_valid(f_pc_valid), .d_pc(d_pc), .d_valid(d_valid),
        .x_pc(x_pc), .x_valid(x_valid), .flush(flush), .x_mispredict(x_mispredict)
    );

    fetch_pc_gen #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .stall(w_zero),
        .f_predict_addr(w_zero32), .f_predict_valid(w_zero),
        .x_branch_valid(w_zero), .x_branch_taken(w_zero),
        .x_branch_target(w_zero32),
`ifdef FETCH_PC_STATS_EN
        .stat_branches(w_sb), .stat_mispredicts(w_sm),
`endif
        .f_pc(w_f_pc), .f_pc_valid(w_f_pc_valid), .d_pc(w_d_pc), .d_valid(w_d_valid),
        .x_pc(w_x_pc), .x_valid(w_x_valid), .flush(w_flush), .x_mispredict(w_x_mispredict)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        stall;
        logic        fpv;
        logic [31:0] fpa;
        logic        xbv;
        logic        xbt;
        logic [31:0] xtg;
        logic [31:0] e_fpc;
        logic        e_fv;
        logic [31:0] e_dpc;
        logic        e_dv;
        logic [31:0] e_xpc;
        logic        e_xv;
        logic        e_fl;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic fpv, input logic [31:0] fpa,
                                input logic xbv, input logic xbt, input logic [31:0] xtg,
                                input logic [31:0] efpc, input logic efv,
                                input logic [31:0] edpc, input logic edv,
                                input logic [31:0] expc, input logic exv, input logic efl);
        vec_t v;
        v.stall = st; v.fpv = fpv; v.fpa = fpa; v.xbv = xbv; v.xbt = xbt; v.xtg = xtg;
        v.e_fpc = efpc; v.e_fv = efv; v.e_dpc = edpc; v.e_dv = edv;
        v.e_xpc = expc; v.e_xv = exv; v.e_fl = efl;
        return v;
    endfunction

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic        v;
        logic        pt;
        logic [31:0] ptg;
    } rec_t;

    logic [31:0] m_fpc;
    logic        m_fv;
    rec_t        pipe [2];   // [0] = D slot, [1] = X slot
    int          m_sb, m_sm;

    task automatic model_reset();
        m_fpc = RPC;
        m_fv  = 1'b0;
        for (int k = 0; k < 2; k++) pipe[k] = '{pc: 32'd0, v: 1'b0, pt: 1'b0, ptg: 32'd0};
        m_sb = 0;
        m_sm = 0;
    endtask

    function automatic logic [31:0] model_actual();
        return x_branch_taken ? x_branch_target : pipe[1].pc + 32'd4;
    endfunction

    function automatic logic model_flush();
        logic [31:0] prd;
        prd = pipe[1].pt ? pipe[1].ptg : pipe[1].pc + 32'd4;
        return pipe[1].v && x_branch_valid && (model_actual() != prd);
    endfunction

    task automatic model_step();
        logic fl;
        fl = model_flush();
        if (pipe[1].v && x_branch_valid) m_sb++;
        if (fl) m_sm++;
        if (fl) begin
            m_fpc      = model_actual();
            pipe[0].v  = 1'b0;
            pipe[1].v  = 1'b0;
        end else if (stall) begin
            pipe[1].v  = 1'b0;
        end else begin
            pipe[1] = pipe[0];
            pipe[0] = '{pc: m_fpc, v: m_fv, pt: f_predict_valid, ptg: f_predict_addr};
            if (m_fv) m_fpc = f_predict_valid ? f_predict_addr : m_fpc + 32'd4;
        end
        m_fv = 1'b1;
    endtask

    task automatic compare_model();
        logic efl;
        efl = model_flush();
        chk("rnd_f_pc", f_pc, m_fpc);
        chk("rnd_f_pc_valid", {31'd0, f_pc_valid}, {31'd0, m_fv});
        chk("rnd_d_valid", {31'd0, d_valid}, {31'd0, pipe[0].v});
        chk("rnd_x_valid", {31'd0, x_valid}, {31'd0, pipe[1].v});
        if (pipe[0].v) chk("rnd_d_pc", d_pc, pipe[0].pc);
        if (pipe[1].v) chk("rnd_x_pc", x_pc, pipe[1].pc);
        chk("rnd_flush", {31'd0, flush}, {31'd0, efl});
        chk("rnd_x_mispredict", {31'd0, x_mispredict}, {31'd0, efl});
    endtask

    task automatic set_inputs(input logic st, input logic fpv, input logic [31:0] fpa,
                              input logic xbv, input logic xbt, input logic [31:0] xtg);
        stall = st; f_predict_valid = fpv; f_predict_addr = fpa;
        x_branch_valid = xbv; x_branch_taken = xbt; x_branch_target = xtg;
    endtask

    initial begin
        int sel;
        //               st fpv fpa           xbv xbt xtg           f_pc          fv d_pc          dv x_pc          xv fl
        vecs[0]  = mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h1000, 0, 32'h0,    0, 32'h0,    0, 0);
        vecs[1]  = mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h1000, 1, 32'h1000, 0, 32'h0,    0, 0);
        vecs[2]  = mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h1004, 1, 32'h1000, 1, 32'h0,    0, 0);
        vecs[3]  = mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h1008, 1, 32'h1004, 1, 32'h1000, 1, 0);
        vecs[4]  = mk(0, 1, 32'h1014, 0, 0, 32'h0,    32'h100c, 1, 32'h1008, 1, 32'h1004, 1, 0);
        vecs[5]  = mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h1014, 1, 32'h100c, 1, 32'h1008, 1, 0);
        vecs[6]  = mk(0, 0, 32'h0,    1, 1, 32'h1014, 32'h1018, 1, 32'h1014, 1, 32'h100c, 1, 0);
        vecs[7]  = mk(0, 1, 32'h3000, 1, 1, 32'h1000, 32'h101c, 1, 32'h1018, 1, 32'h1014, 1, 1);
        vecs[8]  = mk(0, 0, 32'h0,    1, 1, 32'h5000, 32'h1000, 1, 32'h0,    0, 32'h0,    0, 0);
        vecs[9]  = mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h1004, 1, 32'h1000, 1, 32'h0,    0, 0);
        vecs[10] = mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h1008, 1, 32'h1004, 1, 32'h1000, 1, 0);
        vecs[11] = mk(0, 1, 32'h1014, 0, 0, 32'h0,    32'h100c, 1, 32'h1008, 1, 32'h1004, 1, 0);
        vecs[12] = mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h1014, 1, 32'h100c, 1, 32'h1008, 1, 0);
        vecs[13] = mk(0, 0, 32'h0,    1, 0, 32'h1014, 32'h1018, 1, 32'h1014, 1, 32'h100c, 1, 1);
        vecs[14] = mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h1010, 1, 32'h0,    0, 32'h0,    0, 0);
        vecs[15] = mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h1014, 1, 32'h1010, 1, 32'h0,    0, 0);
        vecs[16] = mk(1, 0, 32'h0,    0, 0, 32'h0,    32'h1018, 1, 32'h1014, 1, 32'h1010, 1, 0);
        vecs[17] = mk(1, 0, 32'h0,    0, 0, 32'h0,    32'h1018, 1, 32'h1014, 1, 32'h0,    0, 0);
        vecs[18] = mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h1018, 1, 32'h1014, 1, 32'h0,    0, 0);
        vecs[19] = mk(1, 0, 32'h0,    1, 1, 32'h2000, 32'h101c, 1, 32'h1018, 1, 32'h1014, 1, 1);
        vecs[20] = mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h2000, 1, 32'h0,    0, 32'h0,    0, 0);
        vecs[21] = mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h2004, 1, 32'h2000, 1, 32'h0,    0, 0);

        // reset held for 3 clocks
        rst_n = 1'b0;
        set_inputs(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_f_pc", f_pc, RPC);
        chk("reset_f_pc_valid", {31'd0, f_pc_valid}, 32'd0);
        chk("reset_d_valid", {31'd0, d_valid}, 32'd0);
        chk("reset_x_valid", {31'd0, x_valid}, 32'd0);
        chk("reset_d_pc", d_pc, 32'd0);
        chk("reset_x_pc", x_pc, 32'd0);
        chk("reset_flush", {31'd0, flush}, 32'd0);
        rst_n = 1'b1;

        // directed table
        for (int i = 0; i < NVEC; i++) begin
            set_inputs(vecs[i].stall, vecs[i].fpv, vecs[i].fpa,
                       vecs[i].xbv, vecs[i].xbt, vecs[i].xtg);
            @(negedge clk);
            chk($sformatf("vec%0d_f_pc", i), f_pc, vecs[i].e_fpc);
            chk($sformatf("vec%0d_f_pc_valid", i), {31'd0, f_pc_valid}, {31'd0, vecs[i].e_fv});
            chk($sformatf("vec%0d_d_valid", i), {31'd0, d_valid}, {31'd0, vecs[i].e_dv});
            chk($sformatf("vec%0d_x_valid", i), {31'd0, x_valid}, {31'd0, vecs[i].e_xv});
            if (vecs[i].e_dv) chk($sformatf("vec%0d_d_pc", i), d_pc, vecs[i].e_dpc);
            if (vecs[i].e_xv) chk($sformatf("vec%0d_x_pc", i), x_pc, vecs[i].e_xpc);
            chk($sformatf("vec%0d_flush", i), {31'd0, flush}, {31'd0, vecs[i].e_fl});
            chk($sformatf("vec%0d_x_mispredict", i), {31'd0, x_mispredict}, {31'd0, vecs[i].e_fl});
            if (i == 0) begin
                chk("wrap_boot_pc", w_f_pc, 32'hFFFF_FFFC);
                chk("wrap_boot_valid", {31'd0, w_f_pc_valid}, 32'd0);
            end
            if (i == 1) chk("wrap_first_fetch", w_f_pc, 32'hFFFF_FFFC);
            if (i == 2) chk("wrap_second_fetch", w_f_pc, 32'h0000_0000);
            @(posedge clk);
            #1;
        end
`ifdef FETCH_PC_STATS_EN
        chk("stat_branches_dir", {16'd0, stat_branches}, 32'd4);
        chk("stat_mispredicts_dir", {16'd0, stat_mispredicts}, 32'd3);
`endif

        // randomized run against the model
        rst_n = 1'b0;
        set_inputs(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 2));
            set_inputs($urandom_range(0, 5) == 0,
                       $urandom_range(0, 3) == 0,
                       32'h1000 + ($urandom_range(0, 63) << 2),
                       $urandom_range(0, 1) == 1,
                       $urandom_range(0, 1) == 1,
                       (sel == 0) ? pipe[1].ptg :
                       (sel == 1) ? pipe[1].pc + 32'd4 : 32'h1000 + ($urandom_range(0, 63) << 2));
            if (i == 200) begin
                // asynchronous reset mid-run with a live branch input
                #2;
                rst_n = 1'b0;
                #1;
                chk("midreset_f_pc", f_pc, RPC);
                chk("midreset_f_pc_valid", {31'd0, f_pc_valid}, 32'd0);
                chk("midreset_x_valid", {31'd0, x_valid}, 32'd0);
                chk("midreset_flush", {31'd0, flush}, 32'd0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                model_reset();
                continue;
            end
            @(negedge clk);
            compare_model();
            @(posedge clk);
            model_step();
            #1;
        end
`ifdef FETCH_PC_STATS_EN
        chk("stat_branches_rnd", {16'd0, stat_branches}, m_sb);
        chk("stat_mispredicts_rnd", {16'd0, stat_mispredicts}, m_sm);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Fetch-stage next-PC generator that owns the architectural fetch PC. It drives `f_pc` into the branch predictor and instruction memory, and consumes the predictor's `f_predict_addr`/`f_predict_valid` in the same cycle. It carries each fetched instruction's prediction through D and X, compares it against the EXEC branch outcome, and issues a flush plus redirect on mispredict. It sits directly upstream of `branch_predictor` and closes the loop from EXEC back to FETCH.

## Interface

**Parameters**
- `RESET_PC`, default `32'h0000_1000`: first fetch address after reset.

**Ports**
- `clk` in 1: clock; all state updates on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `stall` in 1: hazard hold; F and D registers keep their values.
- `f_predict_addr` in 32: predicted target for the current `f_pc`.
- `f_predict_valid` in 1: predictor hit and predicted taken for the current `f_pc`.
- `x_branch_valid` in 1: the instruction in X is a resolved branch.
- `x_branch_taken` in 1: actual branch direction.
- `x_branch_target` in 32: actual taken target.
- `f_pc` out 32: current fetch PC.
- `f_pc_valid` out 1: `f_pc` is a real fetch, not a bubble.
- `d_pc` out 32: PC of the instruction in D.
- `d_valid` out 1: D holds a live instruction.
- `x_pc` out 32: PC of the instruction in X.
- `x_valid` out 1: X holds a live instruction.
- `flush` out 1: combinational; kill F and D this cycle.
- `x_mispredict` out 1: combinational; same as `flush`, exported for predictor update.

## Operation

**States**
- BOOT: entered on reset. `f_pc = RESET_PC`, `f_pc_valid = 0`. Moves to RUN on the first clock after `rst_n` deasserts.
- RUN: normal fetch.
- REDIR: one bubble cycle after a flush. `f_pc` already holds the corrected address and `f_pc_valid = 1`; D and X are invalid. Moves to RUN on the next clock.

**Per-stage tracking registers**
- F→D: `{pc, valid, pred_taken, pred_target}`.
- D→X: the same fields.
- Predicted next PC for an instruction: `pred_taken ? pred_target : pc + 4`.

**Mispredict detection**
- Condition: `x_valid && x_branch_valid`.
- Actual next PC: `x_branch_taken ? x_branch_target : x_pc + 4`.
- `flush = x_mispredict = (actual next PC != predicted next PC)`.

**Next-PC priority (highest first)**
1. Reset.
2. Flush: load the actual next PC.
3. `stall`: hold.
4. `f_predict_valid`: load `f_predict_addr`.
5. Otherwise: `f_pc + 4`.

**Arithmetic**
- All additions are 32-bit and wrap modulo 2^32: `32'hFFFF_FFFC + 4 = 0`.
- Low two bits are passed through unchanged; no alignment check is performed.

**Stall**
- F→D registers hold.
- D→X loads a bubble: `x_valid = 0`.
- Flush overrides stall.

**Flush**
- F→D and D→X valid bits clear on the next edge.
- State moves to REDIR.

## Timing

**Reset values**
- `f_pc = RESET_PC`; `f_pc_valid`, `d_valid`, `x_valid` = 0; `d_pc`, `x_pc` = 0.
- `flush` and `x_mispredict` = 0, because `x_valid` is 0.

**Prediction**
- Prediction is zero-bubble: `f_predict_*` sampled at edge t sets `f_pc` at t+1.

**Mispredict**
- Penalty is 2 cycles. Branch in X at cycle t asserts `flush` at t, the corrected `f_pc` is issued at t+1, and that instruction reaches X at t+3.

**Boundary cases**
- Reset asserted mid-operation returns to BOOT immediately (asynchronous); any pending flush is dropped.
- Flush and `f_predict_valid` in the same cycle: flush wins and the prediction is ignored.
- `x_branch_valid` while `x_valid = 0`: ignored, no flush.

## Configuration

- `FETCH_PC_STATS_EN` defined:
  - Adds outputs `stat_branches` [15:0] and `stat_mispredicts` [15:0].
  - `stat_branches` increments on each `x_valid && x_branch_valid`; `stat_mispredicts` increments on each flush.
  - Both saturate at `16'hFFFF` and reset to 0.
- `FETCH_PC_STATS_EN` undefined: the ports and counters do not exist. All other behaviour is identical.

## Test plan

1. **Reset:** hold `rst_n = 0` for 3 clocks, then release → `f_pc = 0x1000` with `f_pc_valid = 0` for one cycle, then 0x1000, 0x1004, 0x1008 valid on consecutive cycles.
2. **Predicted taken:** at `f_pc = 0x100c`, drive `f_predict_valid = 1`, `f_predict_addr = 0x1014` → next `f_pc = 0x1014`. Two cycles later `x_pc = 0x100c`; drive `x_branch_taken = 1`, target 0x1014 → `flush = 0`.
3. **Mispredict, not taken:** same prediction as scenario 2, but X reports `x_branch_taken = 0` → `flush = 1` for one cycle, next `f_pc = 0x1010`, `d_valid = x_valid = 0` for the following cycle.
4. **Mispredict, unpredicted taken:** X at 0x1014 with no prior prediction reports taken to 0x1000 → `flush = 1`, next `f_pc = 0x1000`.
5. **Stall and flush priority:** `stall = 1` for 2 cycles at `f_pc = 0x1008` → `f_pc` and `d_pc` held, `x_valid = 0`. Repeat with a mispredict arriving while `stall = 1` → redirect still taken.
6. **Wrap and stats:** `RESET_PC = 32'hFFFF_FFFC` → second fetch is 0x0. With `FETCH_PC_STATS_EN` defined, run scenarios 2–4 → `stat_branches = 3`, `stat_mispredicts = 2`.
